// File: rtl/demux_pkg.sv
// Channel constants and index helpers shared by the 1-to-5 demux and the 5-to-1 selector side.
package demux_pkg;

    localparam int NUM_CH = 5;
    localparam int SEL_W  = 3;
    localparam logic [SEL_W-1:0] LAST_CH = 3'd4;

    typedef logic [SEL_W-1:0] ch_idx_t;

    function automatic logic ch_in_range(input ch_idx_t c);
        return (c <= LAST_CH);
    endfunction

    function automatic ch_idx_t next_ch(input ch_idx_t c);
        return (c == LAST_CH) ? ch_idx_t'(0) : ch_idx_t'(c + 3'd1);
    endfunction

endpackage

// File: rtl/two_demux5_reg_rise_detect.sv
// Rising-edge detector for a level request: one strobe cycle per 0->1 transition.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic strobe
);

    logic load_q;

    // Resetting high means a level already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            load_q <= RST_VAL;
        else
            load_q <= d;
    end

    assign strobe = d & ~load_q;

endmodule

// File: rtl/two_demux5_reg.sv
// Registered 1-to-5 demultiplexer with manual select or round-robin pointer.
// Optional macro DEMUX_EXCLUSIVE_EN: each write clears all other channels (one-hot valid).
module two_demux5_reg
    import demux_pkg::*;
#(
    parameter int               WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  din,
    input  logic [SEL_W-1:0]  sel,
    input  logic              load,
    input  logic              auto_en,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic [WIDTH-1:0]  out4,
    output logic [NUM_CH-1:0] valid,
    output logic [SEL_W-1:0]  ptr,
    output logic              err
);

    logic             strobe;
    ch_idx_t          target;
    logic             target_ok;
    logic [WIDTH-1:0] ch_q [NUM_CH];

    rise_detect #(
        .RST_VAL (1'b1)
    ) u_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (load),
        .strobe (strobe)
    );

    assign target    = auto_en ? ptr : sel;
    assign target_ok = ch_in_range(target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++)
                ch_q[i] <= RESET_VAL;
            valid <= '0;
            ptr   <= '0;
            err   <= 1'b0;
        end else begin
            // The pointer is always in range, so only a manual select can fault.
            err <= strobe & ~target_ok;
            if (strobe && target_ok) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (target == ch_idx_t'(i)) begin
                        ch_q[i]  <= din;
                        valid[i] <= 1'b1;
                    end else begin
`ifdef DEMUX_EXCLUSIVE_EN
                        ch_q[i]  <= RESET_VAL;
                        valid[i] <= 1'b0;
`endif
                    end
                end
                if (auto_en)
                    ptr <= next_ch(ptr);
            end
        end
    end

    assign out0 = ch_q[0];
    assign out1 = ch_q[1];
    assign out2 = ch_q[2];
    assign out3 = ch_q[3];
    assign out4 = ch_q[4];

endmodule

// File: tb/tb_two_demux5_reg.sv
// Directed bench for two_demux5_reg: per-cycle behavioural model compare plus literal checks.
module tb_two_demux5_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] din;
    logic [2:0] sel;
    logic       load;
    logic       auto_en;
    logic [1:0] out0, out1, out2, out3, out4;
    logic [4:0] valid;
    logic [2:0] ptr;
    logic       err;

    int tests = 0;
    int fails = 0;

    two_demux5_reg #(.WIDTH(2), .RESET_VAL(2'b00)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .load(load), .auto_en(auto_en),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .valid(valid), .ptr(ptr), .err(err)
    );

    always #5 clk = ~clk;

    logic [1:0] dout [5];
    assign dout[0] = out0;
    assign dout[1] = out1;
    assign dout[2] = out2;
    assign dout[3] = out3;
    assign dout[4] = out4;

    // Behavioural model: channel array, written-set, pointer, error flag, last load level.
    logic [1:0] m_out [5];
    logic [4:0] m_valid;
    int         m_ptr;
    logic       m_err;
    logic       m_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) m_out[i] <= 2'b00;
            m_valid <= '0;
            m_ptr   <= 0;
            m_err   <= 1'b0;
            m_prev  <= 1'b1;
        end else begin
            int tgt;
            m_err  <= 1'b0;
            m_prev <= load;
            if (load && !m_prev) begin
                tgt = auto_en ? m_ptr : int'(sel);
                if (tgt < 5) begin
`ifdef DEMUX_EXCLUSIVE_EN
                    for (int i = 0; i < 5; i++) m_out[i] <= 2'b00;
                    m_valid <= 5'b00000;
`endif
                    m_out[tgt]   <= din;
                    m_valid[tgt] <= 1'b1;
                    if (auto_en) m_ptr <= (m_ptr + 1) % 5;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            for (int i = 0; i < 5; i++) check($sformatf("model out%0d", i), 32'(dout[i]), 32'(m_out[i]));
            check("model valid", 32'(valid), 32'(m_valid));
            check("model ptr", 32'(ptr), 32'(m_ptr));
            check("model err", 32'(err), 32'(m_err));
        end
    end

    // One write: load rises at a negedge, the next posedge takes it, load drops again.
    task automatic pulse(input logic [1:0] d, input logic [2:0] s);
        @(negedge clk);
        din  = d;
        sel  = s;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b1; auto_en = 1'b0; sel = 3'd0; din = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset no write valid", 32'(valid), 32'h00);
        check("reset ptr", 32'(ptr), 32'h0);
        check("reset out0", 32'(out0), 32'h0);
        check("reset out4", 32'(out4), 32'h0);
        check("reset err", 32'(err), 32'h0);
        load = 1'b0;

        // Manual write held high for five cycles
        @(negedge clk);
        auto_en = 1'b0; sel = 3'd3; din = 2'b10; load = 1'b1;
        @(posedge clk); #1;
        check("manual out3", 32'(out3), 32'h2);
        check("manual valid", 32'(valid), 32'h08);
        repeat (4) @(negedge clk);
        din = 2'b01;
        @(negedge clk);
        check("manual held out3", 32'(out3), 32'h2);
        check("manual other out2", 32'(out2), 32'h0);
        load = 1'b0;

        // Round-robin through all five channels
        auto_en = 1'b1;
        pulse(2'd1, 3'd0); check("rr ptr 1", 32'(ptr), 32'h1);
        pulse(2'd2, 3'd0); check("rr ptr 2", 32'(ptr), 32'h2);
        pulse(2'd3, 3'd0); check("rr ptr 3", 32'(ptr), 32'h3);
        pulse(2'd0, 3'd0); check("rr ptr 4", 32'(ptr), 32'h4);
        pulse(2'd1, 3'd0); check("rr ptr 0", 32'(ptr), 32'h0);
`ifdef DEMUX_EXCLUSIVE_EN
        check("rr valid", 32'(valid), 32'h10);
        check("rr out0", 32'(out0), 32'h0);
`else
        check("rr valid", 32'(valid), 32'h1f);
        check("rr out0", 32'(out0), 32'h1);
        check("rr out1", 32'(out1), 32'h2);
        check("rr out2", 32'(out2), 32'h3);
        check("rr out3", 32'(out3), 32'h0);
`endif
        check("rr out4", 32'(out4), 32'h1);

        // Invalid manual select, then same select in auto mode
        auto_en = 1'b0;
        @(negedge clk);
        din = 2'd2; sel = 3'd6; load = 1'b1;
        @(posedge clk); #1;
        check("invalid err pulse", 32'(err), 32'h1);
        check("invalid ptr", 32'(ptr), 32'h0);
        @(negedge clk); load = 1'b0;
        @(posedge clk); #1;
        check("invalid err drop", 32'(err), 32'h0);
        auto_en = 1'b1;
        pulse(2'd2, 3'd6);
        check("auto sel6 err", 32'(err), 32'h0);
        check("auto sel6 out0", 32'(out0), 32'h2);
        check("auto sel6 ptr", 32'(ptr), 32'h1);

        // Exclusive option check from a clean state
        @(negedge clk); rst_n = 1'b0; load = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        auto_en = 1'b0;
        pulse(2'd3, 3'd1);
        pulse(2'd2, 3'd4);
`ifdef DEMUX_EXCLUSIVE_EN
        check("excl out1", 32'(out1), 32'h0);
        check("excl valid", 32'(valid), 32'h10);
`else
        check("excl out1", 32'(out1), 32'h3);
        check("excl valid", 32'(valid), 32'h12);
`endif
        check("excl out4", 32'(out4), 32'h2);

        // Reset asserted inside the strobe cycle
        auto_en = 1'b1;
        pulse(2'd1, 3'd0);
        check("pre-reset ptr", 32'(ptr), 32'h1);
        @(negedge clk);
        din = 2'd3; load = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async out4", 32'(out4), 32'h0);
        check("async out0", 32'(out0), 32'h0);
        check("async ptr", 32'(ptr), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post reset valid", 32'(valid), 32'h00);
        check("post reset out1", 32'(out1), 32'h0);
        load = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
